// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared select encodings and register-address constants for operand forwarding
package fwd_pkg;

    localparam int              REGADDR_W = 5;
    localparam logic [4:0]      REG_ZERO  = 5'd0;

    localparam logic [1:0]      SEL_RF    = 2'b00;
    localparam logic [1:0]      SEL_EXMEM = 2'b01;
    localparam logic [1:0]      SEL_MEMWB = 2'b10;

endpackage

// File: rtl/fwd_operand_stage_if.sv
// rtl/fwd_operand_stage_if.sv - decode/forwarding/execute bundle for the operand stage
interface fwd_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int CNTW  = 16
);

    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*5-1:0]     rf_addr;
    logic [NCH*WIDTH-1:0] rf_data;
    logic                 exmem_wr;
    logic [4:0]           exmem_addr;
    logic [WIDTH-1:0]     exmem_data;
    logic                 exmem_is_load;
    logic                 memwb_wr;
    logic [4:0]           memwb_addr;
    logic [WIDTH-1:0]     memwb_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH*2-1:0]     out_sel;
    logic                 load_use_stall;
    logic [CNTW-1:0]      fwd_cnt_exmem;
    logic [CNTW-1:0]      fwd_cnt_memwb;

    modport master (
        output in_valid, rf_addr, rf_data,
        output exmem_wr, exmem_addr, exmem_data, exmem_is_load,
        output memwb_wr, memwb_addr, memwb_data,
        output flush, out_ready,
        input  in_ready, out_valid, out_data, out_sel, load_use_stall,
        input  fwd_cnt_exmem, fwd_cnt_memwb
    );

    modport slave (
        input  in_valid, rf_addr, rf_data,
        input  exmem_wr, exmem_addr, exmem_data, exmem_is_load,
        input  memwb_wr, memwb_addr, memwb_data,
        input  flush, out_ready,
        output in_ready, out_valid, out_data, out_sel, load_use_stall,
        output fwd_cnt_exmem, fwd_cnt_memwb
    );

endinterface

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - per-channel forwarding source select and load-use hazard detect
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REGADDR_W-1:0] rf_addr,
    input  logic                 exmem_wr,
    input  logic [REGADDR_W-1:0] exmem_addr,
    input  logic                 exmem_is_load,
    input  logic                 memwb_wr,
    input  logic [REGADDR_W-1:0] memwb_addr,
    output logic [1:0]           sel,
    output logic                 hazard
);

    // The younger EX/MEM result wins; $0 is hardwired and never forwarded.
    always_comb begin
        sel = SEL_RF;
        if (exmem_wr && (exmem_addr != REG_ZERO) && (exmem_addr == rf_addr)) begin
            sel = SEL_EXMEM;
        end else if (memwb_wr && (memwb_addr != REG_ZERO) && (memwb_addr == rf_addr)) begin
            sel = SEL_MEMWB;
        end
    end

    assign hazard = (sel == SEL_EXMEM) && exmem_is_load;

endmodule

// File: rtl/fwd_operand_stage.sv
// rtl/fwd_operand_stage.sv - ID/EX operand register with forwarding mux, load-use stall and statistics
module fwd_operand_stage
    import fwd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int CNTW  = 16
) (
    input  logic                clk,
    input  logic                reset,
    fwd_operand_stage_if.slave  bus
);

    localparam int              INCW    = $clog2(NCH + 1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [NCH*2-1:0]     sel;
    logic [NCH-1:0]       hazard;
    logic [NCH*WIDTH-1:0] mux_data;
    logic [INCW-1:0]      n_exmem;
    logic [INCW-1:0]      n_memwb;
    logic                 stall;
    logic                 ready;
    logic                 capture;

    logic                 valid_q, valid_d;
    logic [NCH*WIDTH-1:0] data_q, data_d;
    logic [NCH*2-1:0]     sel_q, sel_d;
    logic [CNTW-1:0]      cnt_exmem_q, cnt_exmem_d;
    logic [CNTW-1:0]      cnt_memwb_q, cnt_memwb_d;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        fwd_match u_match (
            .rf_addr       (bus.rf_addr[REGADDR_W*k +: REGADDR_W]),
            .exmem_wr      (bus.exmem_wr),
            .exmem_addr    (bus.exmem_addr),
            .exmem_is_load (bus.exmem_is_load),
            .memwb_wr      (bus.memwb_wr),
            .memwb_addr    (bus.memwb_addr),
            .sel           (sel[2*k +: 2]),
            .hazard        (hazard[k])
        );
    end

    always_comb begin
        mux_data = '0;
        n_exmem  = '0;
        n_memwb  = '0;
        for (int k = 0; k < NCH; k++) begin
            case (sel[2*k +: 2])
                SEL_EXMEM: begin
                    mux_data[WIDTH*k +: WIDTH] = bus.exmem_data;
                    n_exmem = n_exmem + INCW'(1);
                end
                SEL_MEMWB: begin
                    mux_data[WIDTH*k +: WIDTH] = bus.memwb_data;
                    n_memwb = n_memwb + INCW'(1);
                end
                default: mux_data[WIDTH*k +: WIDTH] = bus.rf_data[WIDTH*k +: WIDTH];
            endcase
        end
    end

    // One spare bit is enough since the per-cycle increment never exceeds NCH.
    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [INCW-1:0] b);
        logic [CNTW:0] s;
        s = {1'b0, a} + (CNTW+1)'(b);
        return s[CNTW] ? CNT_MAX : s[CNTW-1:0];
    endfunction

    assign stall   = bus.in_valid && (|hazard);
    assign ready   = (!valid_q || bus.out_ready) && !stall;
    assign capture = bus.in_valid && ready && !bus.flush;

    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        sel_d       = sel_q;
        cnt_exmem_d = cnt_exmem_q;
        cnt_memwb_d = cnt_memwb_q;
        if (capture) begin
            valid_d     = 1'b1;
            data_d      = mux_data;
            sel_d       = sel;
            cnt_exmem_d = sat_add(cnt_exmem_q, n_exmem);
            cnt_memwb_d = sat_add(cnt_memwb_q, n_memwb);
        end else if (bus.flush || bus.out_ready) begin
            valid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            sel_q       <= '0;
            cnt_exmem_q <= '0;
            cnt_memwb_q <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            cnt_exmem_q <= cnt_exmem_d;
            cnt_memwb_q <= cnt_memwb_d;
        end
    end

    assign bus.in_ready       = ready;
    assign bus.load_use_stall = stall;
    assign bus.out_valid      = valid_q;
    assign bus.out_data       = data_q;
    assign bus.out_sel        = sel_q;
    assign bus.fwd_cnt_exmem  = cnt_exmem_q;
    assign bus.fwd_cnt_memwb  = cnt_memwb_q;

endmodule
